tune_pwm_bank: RTL and testbench
================================

# tune_pwm_bank

Multi-channel tone generator for the MUSIC subsystem. Each channel is an independent period counter with a programmable duty threshold, producing one square/PWM output per channel. New period/duty values are written through a valid/ready port and staged per channel. Staged values take effect only at that channel's period wrap, so outputs never glitch mid-period. The block feeds the audio output stage and replaces single-channel, fixed-50% tone generation.

## Interface
- `CH`, 2, number of channels (1..8)
- `CW`, 20, period counter width
- `DW`, 8, duty fraction width (duty/2^DW)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  global count enable; counters and outputs hold when low
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_ch`  in  $clog2(CH) (min 1)  target channel
- `wr_period`  in  CW  max count P; 0 = channel muted
- `wr_duty`  in  DW  duty fraction
- `pwm`  out  CH  per-channel tone output, registered
- `wrap`  out  CH  one-cycle pulse when a channel's counter wraps
- `mix_level`  out  $clog2(CH+1)  number of channels currently high; only present with `TUNE_PWM_MIX_EN`

## Operation
- Per-channel active registers: `per` (CW), `thr` (CW+1), `cnt` (CW). Per-channel staging: `st_per`, `st_duty`, `pend`.
- Threshold: `thr = ((per+1) * duty) >> DW`, computed at commit. Product width is CW+1+DW. No truncation before the shift.
- Counting: when `en && per!=0`, `cnt` increments. When `cnt==per`, `cnt` goes to 0 and `wrap[i]` = 1 for that cycle.
- Output: `pwm[i]` is registered from `(per!=0) && (cnt_next < thr)`. `duty=0` keeps the output low. `duty=2^DW-1` gives high for ((P+1)(2^DW-1))>>DW counts per period.
- Write path:
  - `wr_ready = !pend[wr_ch]`, combinational from `wr_ch`.
  - An accepted write loads the staging registers and sets `pend`.
  - A write with out-of-range `wr_ch` (≥CH) is accepted and discarded.
- Commit, for a channel with `pend` set:
  - If the channel is running (`en && per!=0`): on its wrap cycle, `per` and `thr` load from staging, `cnt` = 0, `pend` clears.
  - If `per==0` (muted): commit on the cycle after acceptance, independent of `en`.
- Simultaneous events:
  - A write accepted on the same cycle as a commit of that channel is impossible, because `wr_ready` is 0 while `pend` is set.
  - Writes to other channels proceed freely.
- `en` low: `cnt`, `pwm`, and `pend` hold. No wrap occurs. Muted-channel commits still occur.
- Muting: writing `wr_period=0` to a running channel mutes it at the next wrap. After that commit, `pwm` = 0 and `cnt` = 0.

## Timing
- Reset values: `cnt`, `per`, `thr`, `st_*`, `pend` = 0; `pwm` = 0; `wrap` = 0; `mix_level` = 0. After reset, `wr_ready` = 1.
- Reset asserted mid-period clears all state immediately, including pending writes.
- Output follows the counter with one cycle of register latency. The period is exactly P+1 enabled cycles.
- Write acceptance to a muted channel → output may go high 2 cycles later.
- Write acceptance to a running channel → takes effect at the first sample after the next wrap. The maximum delay is P+1 enabled cycles.
- `wrap` is combinational from registered state and is asserted during the cycle where `cnt==per`.

## Configuration
- `TUNE_PWM_MIX_EN` defined: adds the `mix_level` output, a registered popcount of the next `pwm` value. It updates in the same cycle as `pwm` and is used by a downstream DAC mixer.
- Not defined: the `mix_level` port and the popcount logic are absent. All other behaviour is identical.

## Structure
- `tune_pwm_pkg`: default `CW`/`DW`/`CH` constants, a function for the threshold computation, and the channel-index width helper.
- Sub-module `tune_pwm_chan`, one per channel: holds the counter, active and staging registers, commit logic, and the `pwm`/`wrap` outputs.
- The top level holds the write decode, `wr_ready` mux, and optional mixer.

## Test plan
All scenarios use CH=2, CW=20, DW=8.
- Reset, then write ch0 P=9 duty=128 with `en`=1 → `thr`=5. `pwm[0]` is high 5 of every 10 cycles. `wrap[0]` pulses every 10 cycles.
- ch0 running at P=9, then write P=19 duty=64 → `wr_ready` is 0 for ch0 until the wrap. The old 10-cycle period completes. Then the period is 20 with 5 high cycles. No glitch.
- Duty boundaries at P=9: duty=0 → `pwm` constant 0. duty=255 → high 9 of 10 cycles.
- Deassert `en` for 7 cycles mid-period → `cnt` and `pwm` freeze, no wrap occurs, and counting resumes where it stopped.
- Both channels active (P=3 and P=5, duty=128) with `TUNE_PWM_MIX_EN` defined → `mix_level` equals the count of high bits in `pwm` on every cycle. Also write P=0 to ch1 and check `pwm[1]` = 0 after ch1's next wrap.
- Assert `rst` while ch0 has `pend` set → all outputs are 0 and `wr_ready` is 1. After reset, ch0 stays muted.

Source files
------------

// File: rtl/tune_pwm_pkg.sv
// Shared constants and helpers for the tune_pwm bank.
package tune_pwm_pkg;

   localparam int unsigned CH_DEF = 2;
   localparam int unsigned CW_DEF = 20;
   localparam int unsigned DW_DEF = 8;

   // Width of a channel index, never below one bit.
   function automatic int unsigned ch_idx_w(input int unsigned ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   // thr = ((per+1) * duty) >> dw, evaluated at full width before the shift.
   function automatic logic [63:0] calc_thr(input logic [63:0] per,
                                            input logic [63:0] duty,
                                            input int unsigned dw);
      return ((per + 64'd1) * duty) >> dw;
   endfunction

endpackage

// File: rtl/tune_pwm_chan.sv
// One tone channel: period counter, active/staged settings, wrap-aligned commit, PWM output.
// Optional TUNE_PWM_MIX_EN exposes the next-state pwm bit for the bank mixer.
module tune_pwm_chan
   import tune_pwm_pkg::*;
#(
   parameter int unsigned CW = CW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          load,
   input  logic [CW-1:0] period,
   input  logic [DW-1:0] duty,
   output logic          pend,
   output logic          pwm,
   output logic          wrap
`ifdef TUNE_PWM_MIX_EN
   ,
   output logic          pwm_next
`endif
);

   logic [CW-1:0] per_q, per_d, cnt_q, cnt_d, st_per_q;
   logic [CW:0]   thr_q, thr_d;
   logic [DW-1:0] st_duty_q;
   logic          pend_q, pwm_q, pwm_d, run, commit;

   // Counter advance, commit decision and next output level.
   always_comb begin
      run    = en && (per_q != '0);
      wrap   = run && (cnt_q == per_q);
      // Muted channels commit right away; running ones only on their wrap.
      commit = pend_q && (wrap || (per_q == '0));
      per_d  = per_q;
      thr_d  = thr_q;
      cnt_d  = cnt_q;
      pwm_d  = pwm_q;
      if (commit) begin
         per_d = st_per_q;
         thr_d = (CW+1)'(calc_thr(64'(st_per_q), 64'(st_duty_q), DW));
         cnt_d = '0;
      end else if (run) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      if (commit || run) begin
         pwm_d = (per_d != '0) && ({1'b0, cnt_d} < thr_d);
      end
   end

   // Active state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_q <= '0;
         thr_q <= '0;
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         per_q <= per_d;
         thr_q <= thr_d;
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   // Staging registers; a load cannot coincide with a commit since ready is low while pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_per_q  <= '0;
         st_duty_q <= '0;
         pend_q    <= 1'b0;
      end else begin
         if (load) begin
            st_per_q  <= period;
            st_duty_q <= duty;
         end
         if (commit) begin
            pend_q <= 1'b0;
         end else if (load) begin
            pend_q <= 1'b1;
         end
      end
   end

   assign pend = pend_q;
   assign pwm  = pwm_q;
`ifdef TUNE_PWM_MIX_EN
   assign pwm_next = pwm_d;
`endif

endmodule

// File: rtl/tune_pwm_bank.sv
// Multi-channel tone/PWM bank: write decode, per-channel ready mux, optional mixer.
// Defining TUNE_PWM_MIX_EN adds the registered mix_level popcount output.
module tune_pwm_bank
   import tune_pwm_pkg::*;
#(
   parameter int unsigned CH  = CH_DEF,
   parameter int unsigned CW  = CW_DEF,
   parameter int unsigned DW  = DW_DEF,
   localparam int unsigned CIW = ch_idx_w(CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [CIW-1:0]           wr_ch,
   input  logic [CW-1:0]            wr_period,
   input  logic [DW-1:0]            wr_duty,
   output logic [CH-1:0]            pwm,
   output logic [CH-1:0]            wrap
`ifdef TUNE_PWM_MIX_EN
   ,
   output logic [$clog2(CH+1)-1:0]  mix_level
`endif
);

   logic [CH-1:0]       pend;
   logic [2**CIW-1:0]   pend_ext;
`ifdef TUNE_PWM_MIX_EN
   logic [CH-1:0]       pwm_next;
`endif

   // Pad pending flags so out-of-range channel indices read as ready and get discarded.
   always_comb begin
      pend_ext          = '0;
      pend_ext[CH-1:0]  = pend;
   end

   assign wr_ready = !pend_ext[wr_ch];

   for (genvar i = 0; i < CH; i++) begin : g_chan
      logic load;
      assign load = wr_valid && wr_ready && (wr_ch == CIW'(i));

      tune_pwm_chan #(
         .CW (CW),
         .DW (DW)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .load     (load),
         .period   (wr_period),
         .duty     (wr_duty),
         .pend     (pend[i]),
         .pwm      (pwm[i]),
         .wrap     (wrap[i])
`ifdef TUNE_PWM_MIX_EN
         ,
         .pwm_next (pwm_next[i])
`endif
      );
   end

`ifdef TUNE_PWM_MIX_EN
   localparam int unsigned MW = $clog2(CH+1);
   logic [MW-1:0] mix_d;

   // Popcount of the next pwm vector so mix_level lands on the same edge as pwm.
   always_comb begin
      mix_d = '0;
      for (int k = 0; k < CH; k++) begin
         mix_d = mix_d + MW'(pwm_next[k]);
      end
   end

   // Mixer level register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_level <= '0;
      end else begin
         mix_level <= mix_d;
      end
   end
`endif

endmodule

// File: tb/tb_tune_pwm_bank.sv
// Scoreboard bench for tune_pwm_bank (CH=2, CW=20, DW=8); mix_level checked with TUNE_PWM_MIX_EN.
module tb_tune_pwm_bank;

   localparam int unsigned CH = 2;
   localparam int unsigned CW = 20;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          wr_valid;
   logic          wr_ready;
   logic [0:0]    wr_ch;
   logic [CW-1:0] wr_period;
   logic [DW-1:0] wr_duty;
   logic [CH-1:0] pwm;
   logic [CH-1:0] wrap;
`ifdef TUNE_PWM_MIX_EN
   logic [1:0]    mix_level;
`endif

   tune_pwm_bank #(
      .CH (CH),
      .CW (CW),
      .DW (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_ch     (wr_ch),
      .wr_period (wr_period),
      .wr_duty   (wr_duty),
      .pwm       (pwm),
      .wrap      (wrap)
`ifdef TUNE_PWM_MIX_EN
      ,
      .mix_level (mix_level)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] pwm;
      logic [1:0] wrap;
      logic       rdy;
      logic [1:0] mix;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model: each channel's active period/threshold/phase plus a staged request.
   int unsigned m_per[CH], m_thr[CH], m_cnt[CH], m_stp[CH], m_std[CH];
   bit          m_pend[CH];

   function automatic void model_clear();
      for (int i = 0; i < CH; i++) begin
         m_per[i] = 0; m_thr[i] = 0; m_cnt[i] = 0;
         m_stp[i] = 0; m_std[i] = 0; m_pend[i] = 0;
      end
   endfunction

   // Outputs visible during the current cycle, derived from the model state.
   function automatic exp_t make_exp(input bit e, input int ch);
      exp_t x;
      int   hi;
      x  = '0;
      hi = 0;
      for (int i = 0; i < CH; i++) begin
         x.pwm[i]  = (m_per[i] != 0) && (m_cnt[i] < m_thr[i]);
         x.wrap[i] = e && (m_per[i] != 0) && (m_cnt[i] == m_per[i]);
         hi += int'(x.pwm[i]);
      end
      x.rdy = !m_pend[ch];
      x.mix = 2'(hi);
      return x;
   endfunction

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b1; en = 1'b0; wr_valid = 1'b0;
         model_clear();
         sb.push_back(make_exp(1'b0, int'(wr_ch)));
      end
   endtask

   task automatic step(input bit e, input bit v, input int ch,
                       input int unsigned p, input int unsigned d);
      bit acc, run, wr, cm;
      @(negedge clk);
      rst = 1'b0; en = e; wr_valid = v;
      wr_ch = 1'(ch); wr_period = CW'(p); wr_duty = DW'(d);
      sb.push_back(make_exp(e, ch));
      acc = v && !m_pend[ch];
      for (int i = 0; i < CH; i++) begin
         run = e && (m_per[i] != 0);
         wr  = run && (m_cnt[i] == m_per[i]);
         cm  = m_pend[i] && (wr || (m_per[i] == 0));
         if (cm) begin
            m_per[i]  = m_stp[i];
            m_thr[i]  = ((m_stp[i] + 1) * m_std[i]) / (1 << DW);
            m_cnt[i]  = 0;
            m_pend[i] = 0;
         end else if (run) begin
            m_cnt[i] = wr ? 0 : m_cnt[i] + 1;
         end
      end
      if (acc) begin
         m_stp[ch] = p; m_std[ch] = d; m_pend[ch] = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, int'($urandom_range(0, 1)), 0, 0);
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp_v);
      end
   endtask

   exp_t mon_e;

   // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
   always @(negedge clk) begin
      #2;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         cyc++;
         chk("pwm", int'(pwm), int'(mon_e.pwm));
         chk("wrap", int'(wrap), int'(mon_e.wrap));
         chk("wr_ready", int'(wr_ready), int'(mon_e.rdy));
`ifdef TUNE_PWM_MIX_EN
         chk("mix_level", int'(mix_level), int'(mon_e.mix));
`endif
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned p, d;
      rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_ch = '0; wr_period = '0; wr_duty = '0;
      model_clear();
      do_reset(3);

      // P=9 duty=128, then retune to P=19 duty=64 while running.
      step(1'b1, 1'b1, 0, 9, 128);
      idle(30);
      step(1'b1, 1'b1, 0, 19, 64);
      repeat (12) step(1'b1, 1'b0, 0, 0, 0);
      idle(45);
      // Duty boundaries.
      step(1'b1, 1'b1, 0, 9, 0);
      idle(45);
      step(1'b1, 1'b1, 0, 9, 255);
      idle(45);
      // Enable gap mid-period.
      idle(4);
      repeat (7) step(1'b0, 1'b0, 0, 0, 0);
      idle(20);
      // Two channels, then mute ch1.
      step(1'b1, 1'b1, 0, 3, 128);
      step(1'b1, 1'b1, 1, 5, 128);
      idle(30);
      step(1'b1, 1'b1, 1, 0, 0);
      idle(20);
      // Reset while ch0 has a pending write; ch0 must stay muted afterwards.
      step(1'b1, 1'b1, 0, 19, 128);
      do_reset(2);
      idle(12);

      // Randomized traffic with occasional enable gaps and resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset(1);
         end else if ($urandom_range(0, 59) == 0) begin
            repeat (7) step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                            $urandom_range(0, 12), $urandom_range(0, 255));
         end else begin
            p = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            case ($urandom_range(0, 3))
               0:       d = 0;
               1:       d = 255;
               default: d = $urandom_range(0, 255);
            endcase
            step(1'($urandom_range(0, 99) < 90), 1'($urandom_range(0, 99) < 15),
                 int'($urandom_range(0, 1)), p, d);
         end
      end

      repeat (3) @(negedge clk);
      #4;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
